// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-request load/store controller in front of the byte-addressed data ram
// Optional LSU_MISALIGN_TRAP_EN rejects accesses whose address is not a multiple of the access size.
`ifndef XLEN
`define XLEN 64
`endif

module lsu_mem_ctrl #(
  parameter int         XLEN      = `XLEN,
  parameter logic [9:0] ADDR_MASK = 10'h3FF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic [XLEN-1:0] ram_addr_o,
  output logic            ram_ren_o,
  output logic            ram_wen_o,
  output logic [7:0]      ram_byte_en_o,
  output logic [XLEN-1:0] ram_wdata_o,
  input  logic [XLEN-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, load_ext;
  logic            err_q, reject, access;
  logic [7:0]      size_mask;

  always_comb begin
    reject = req_we_i ? req_funct3_i[2] : (req_funct3_i == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3_i[1:0])
      2'b01:   if (req_addr_i[0])      reject = 1'b1;
      2'b10:   if (|req_addr_i[1:0])   reject = 1'b1;
      2'b11:   if (|req_addr_i[2:0])   reject = 1'b1;
      default: ;
    endcase
`endif
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){ram_rdata_i[7]}},   ram_rdata_i[7:0]};
      3'b001:  load_ext = {{(XLEN-16){ram_rdata_i[15]}}, ram_rdata_i[15:0]};
      3'b010:  load_ext = {{(XLEN-32){ram_rdata_i[31]}}, ram_rdata_i[31:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}},  ram_rdata_i[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, ram_rdata_i[15:0]};
      3'b110:  load_ext = {{(XLEN-32){1'b0}}, ram_rdata_i[31:0]};
      default: load_ext = ram_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = reject ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        we_q     <= req_we_i;
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
        rdata_q  <= '0;
        err_q    <= reject;
      end else if (state_q == ACCESS && !we_q) begin
        rdata_q <= load_ext;
      end
    end
  end

  // Reset in the access cycle suppresses the strobes so a pending store never commits.
  assign access        = (state_q == ACCESS) && !rst;
  assign ram_addr_o    = access ? (addr_q & XLEN'(ADDR_MASK)) : '0;
  assign ram_ren_o     = access && !we_q;
  assign ram_wen_o     = access && we_q;
  assign ram_byte_en_o = (access && we_q) ? size_mask : 8'h00;
  assign ram_wdata_o   = (access && we_q) ? wdata_q : '0;

  assign req_ready_o   = (state_q == IDLE);
  assign resp_valid_o  = (state_q == RESP);
  assign resp_rdata_o  = (state_q == RESP) ? rdata_q : '0;
  assign resp_err_o    = (state_q == RESP) && err_q;

endmodule
